// File: rtl/walk_voice_bank.sv
// Bank of CHANNELS gated voices (LFO-modulated square x ASR envelope) mixed to one
// saturated signed sample. Every register advances only on audio_clk_en ticks.
//   state   | meaning
//   IDLE    | silent, env=0, waiting for enable
//   ATTACK  | env rising by ATTACK_STEP toward full scale
//   SUSTAIN | env held at full scale while enabled
//   RELEASE | env falling by RELEASE_STEP toward zero
module walk_voice_bank #(
  parameter int CHANNELS     = 2,
  parameter int WIDTH        = 16,
  parameter int LEVEL        = 6826,
  parameter int BASE_INC     = 262144,
  parameter int LFO_STEP     = 64,
  parameter int DEPTH_SHIFT  = 4,
  parameter int ATTACK_STEP  = 512,
  parameter int RELEASE_STEP = 128,
  parameter int MIX_SHIFT    = 0
) (
  input  logic                    clk,
  input  logic                    I_RST,
  input  logic                    audio_clk_en,
  input  logic [CHANNELS-1:0]     enable,
  output logic signed [WIDTH-1:0] out,
  output logic [CHANNELS-1:0]     active
);
  localparam int SW = WIDTH + 4;
  localparam logic [14:0]          ENV_MAX    = 15'h7fff;
  localparam logic signed [16:0]   LEVEL_S    = 17'(LEVEL);
  localparam logic signed [17:0]   LFO_STEP_S = 18'(LFO_STEP);
  localparam logic signed [17:0]   LFO_MAX    = 18'sd32767;
  localparam logic signed [17:0]   LFO_MIN    = -18'sd32767;
  localparam logic signed [25:0]   BASE_S     = 26'(BASE_INC);
  localparam logic signed [SW-1:0] SAT_HI     = {5'b00000, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_LO     = {5'b11111, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  state_t             state    [CHANNELS];
  logic [14:0]        env      [CHANNELS];
  logic signed [15:0] lfo      [CHANNELS];
  logic               lfo_down [CHANNELS];
  logic [23:0]        phase    [CHANNELS];

  logic [15:0]        env_add      [CHANNELS];
  logic [14:0]        env_up       [CHANNELS];
  logic [14:0]        env_dn       [CHANNELS];
  logic signed [17:0] lfo_sum      [CHANNELS];
  logic signed [15:0] lfo_nxt      [CHANNELS];
  logic               lfo_down_nxt [CHANNELS];
  logic signed [25:0] inc_s        [CHANNELS];
  logic [23:0]        phase_inc    [CHANNELS];
  logic signed [16:0] sq           [CHANNELS];
  logic signed [31:0] prod         [CHANNELS];
  logic signed [15:0] voice_smp    [CHANNELS];

  logic signed [SW-1:0]    mix_sum;
  logic signed [SW-1:0]    mix_shr;
  logic signed [WIDTH-1:0] mix_sat;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      env_add[i] = {1'b0, env[i]} + 16'(ATTACK_STEP);
      env_up[i]  = (env_add[i] >= {1'b0, ENV_MAX}) ? ENV_MAX : env_add[i][14:0];
      env_dn[i]  = (env[i] <= 15'(RELEASE_STEP)) ? 15'd0 : env[i] - 15'(RELEASE_STEP);

      // Triangle LFO folds at +/-32767 rather than wrapping.
      lfo_nxt[i]      = lfo[i];
      lfo_down_nxt[i] = lfo_down[i];
      if (!lfo_down[i]) begin
        lfo_sum[i] = 18'(lfo[i]) + LFO_STEP_S;
        if (lfo_sum[i] >= LFO_MAX) begin
          lfo_nxt[i]      = 16'sd32767;
          lfo_down_nxt[i] = 1'b1;
        end else begin
          lfo_nxt[i] = lfo_sum[i][15:0];
        end
      end else begin
        lfo_sum[i] = 18'(lfo[i]) - LFO_STEP_S;
        if (lfo_sum[i] <= LFO_MIN) begin
          lfo_nxt[i]      = -16'sd32767;
          lfo_down_nxt[i] = 1'b0;
        end else begin
          lfo_nxt[i] = lfo_sum[i][15:0];
        end
      end

      inc_s[i]     = BASE_S + 26'(lfo[i] >>> DEPTH_SHIFT);
      phase_inc[i] = (inc_s[i] < 26'sd1) ? 24'd1 : inc_s[i][23:0];

      sq[i]        = phase[i][23] ? -LEVEL_S : LEVEL_S;
      prod[i]      = 32'(sq[i]) * 32'($signed({1'b0, env[i]}));
      voice_smp[i] = 16'(prod[i] >>> 15);
    end
  end

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      mix_sum = mix_sum + SW'(voice_smp[i]);
    end
    mix_shr = mix_sum >>> MIX_SHIFT;
    if (mix_shr > SAT_HI)      mix_sat = SAT_HI[WIDTH-1:0];
    else if (mix_shr < SAT_LO) mix_sat = SAT_LO[WIDTH-1:0];
    else                       mix_sat = mix_shr[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (I_RST) begin
      out    <= '0;
      active <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state[i]    <= IDLE;
        env[i]      <= '0;
        lfo[i]      <= '0;
        lfo_down[i] <= 1'b0;
        phase[i]    <= '0;
      end
    end else if (audio_clk_en) begin
      out <= mix_sat;
      for (int i = 0; i < CHANNELS; i++) begin
        active[i] <= (state[i] != IDLE);
        if (state[i] != IDLE) begin
          lfo[i]      <= lfo_nxt[i];
          lfo_down[i] <= lfo_down_nxt[i];
          phase[i]    <= phase[i] + phase_inc[i];
        end
        case (state[i])
          IDLE: begin
            env[i] <= '0;
            if (enable[i]) begin
              state[i]    <= ATTACK;
              lfo[i]      <= '0;
              lfo_down[i] <= 1'b0;
              phase[i]    <= '0;
            end
          end
          ATTACK: begin
            if (!enable[i]) begin
              state[i] <= RELEASE;
            end else begin
              env[i] <= env_up[i];
              if (env_up[i] == ENV_MAX) state[i] <= SUSTAIN;
            end
          end
          SUSTAIN: begin
            if (!enable[i]) state[i] <= RELEASE;
          end
          RELEASE: begin
            // Retrigger resumes the attack from the current level; no click to zero.
            if (enable[i]) begin
              state[i] <= ATTACK;
            end else begin
              env[i] <= env_dn[i];
              if (env_dn[i] == 15'd0) state[i] <= IDLE;
            end
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/walk_voice_bank.md
Name: walk_voice_bank

Overview:
- Parametrised successor of the single-voice walk sound generator.
- Provides CHANNELS independent gated voices. Each voice has a triangle-LFO-modulated square oscillator, an attack/sustain/release envelope FSM and retrigger handling.
- Voices are summed through a saturating mixer to one signed audio sample.
- Sits between the game-logic sound latch bits and the audio output mixer; all state advances only on audio_clk_en sample ticks.

Parameters:
- CHANNELS, 2, number of independent voices (1..8).
- WIDTH, 16, output sample width (16..24).
- LEVEL, 6826, square amplitude in counts (5 V on the 12 V / 2^14 scale).
- BASE_INC, 262144, 24-bit phase-accumulator increment per tick.
- LFO_STEP, 64, triangle LFO increment per tick.
- DEPTH_SHIFT, 4, LFO-to-pitch scaling: pitch increment = BASE_INC + (lfo >>> DEPTH_SHIFT).
- ATTACK_STEP, 512, envelope rise per tick.
- RELEASE_STEP, 128, envelope fall per tick.
- MIX_SHIFT, 0, arithmetic right shift applied to the channel sum before saturation.

Ports:
- clk  in  1  system clock.
- I_RST  in  1  synchronous active-high reset.
- audio_clk_en  in  1  one-cycle sample tick.
- enable  in  CHANNELS  per-voice gate, level sensitive, sampled on ticks.
- out  out  WIDTH  signed mixed sample.
- active  out  CHANNELS  bit i = voice i not IDLE.

Behaviour:
- One clock.
- Reset is synchronous and active-high (I_RST). It takes priority over audio_clk_en.
- On reset:
  - out=0, active=0.
  - Per voice: state=IDLE, env=0, lfo=0, lfo_dir=up, phase=0.
- Reset asserted mid-note: out=0 and active=0 on the next clk edge; no release tail.
- audio_clk_en low: every register holds.
- Envelope FSM per voice, evaluated only on ticks. env is unsigned 0..32767.
  - IDLE: env=0. If enable=1 → ATTACK; lfo←0, lfo_dir←up, phase←0.
  - ATTACK: if enable=0 → RELEASE. Else env←min(env+ATTACK_STEP, 32767); on reaching 32767 → SUSTAIN.
  - SUSTAIN: env holds. If enable=0 → RELEASE.
  - RELEASE: if enable=1 → ATTACK (retrigger); env continues from its current value, lfo and phase are not reset. Else env←max(env−RELEASE_STEP, 0); on reaching 0 → IDLE.
  - The transition and the env update for that tick happen together, using the pre-tick state.
- LFO per voice: signed 16-bit, advances only when the voice is not IDLE.
  - Going up: lfo+LFO_STEP ≥ 32767 → lfo=32767 and lfo_dir←down; otherwise add.
  - Going down: lfo−LFO_STEP ≤ −32767 → lfo=−32767 and lfo_dir←up; otherwise subtract.
- Oscillator per voice:
  - 24-bit phase accumulator, wraps mod 2^24; advances only when the voice is not IDLE.
  - Increment = BASE_INC + (lfo >>> DEPTH_SHIFT), clamped to a minimum of 1.
  - sq = phase[23] ? −LEVEL : +LEVEL.
- Voice sample = (sq × env) >>> 15: signed 32-bit product, arithmetic shift, result is 16-bit.
- Mixer:
  - sum = Σ voice samples, sign-extended to WIDTH+4 bits, then >>> MIX_SHIFT.
  - Saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Latency:
  - out and active register on the tick from pre-tick voice state, i.e. one sample behind the envelope/phase registers.
  - An enable change is first visible on active two ticks after it is sampled.

Test Plan:
- Reset: pulse I_RST for 3 cycles with ticks running and enable=all-ones → out=0 and active=0 during reset and on the first post-reset tick.
- Attack timing (CHANNELS=1, defaults, LFO_STEP=0): enable↑ → SUSTAIN entered after 64 ticks (32767/512 rounded up); env=32767; active=1 from the second tick after enable↑.
- Oscillator (LFO_STEP=0, BASE_INC=262144, sustained): out is a period-64-tick square, 32 ticks at +6825 and 32 ticks at −6826.
- Release: enable↓ in SUSTAIN (RELEASE_STEP=128) → voice enters IDLE after 256 ticks; active falls one tick later; out=0 thereafter.
- Retrigger: enable↑ in RELEASE at env=16000 → next env=16512 (no drop to 0); lfo and phase continue uninterrupted.
- Saturation: CHANNELS=8, LEVEL=8000, all voices sustained and in phase → out=+32767 on high half-cycles (8×7999 clipped) and −32768 on low half-cycles; with audio_clk_en held low for 100 cycles, out is unchanged.
